// File: rtl/data_bus_node.sv
// data_bus_node: one node on a shared tri-state word bus.
//
// Every node runs the same FIFO-backed FSM and watches the same bus, so all nodes step
// through Idle -> Wait -> Own in lockstep. In Idle only the control node may drive, and the
// word it drives is a header naming the source and destination. After OWNER_WAIT cycles in
// Wait the named source owns the bus until it drives a word flagged with bus_last.
// Received words are buffered in a per-node RX FIFO. If the FIFO is full, new words are
// dropped and a sticky overflow flag is set.
//
// Optional feature macro: DATA_BUS_WDOG_EN enables the Own-state watchdog. With the macro
// undefined there is no watchdog logic, wdog_abort_o is tied low and TIMEOUT is unused.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (all nodes reset together)
//   node_id_i        static ID of this node
//   send_*           word source; a transfer happens when send_valid_i & send_ready_o
//   recv_*           RX FIFO head; a pop happens when recv_valid_o & recv_ready_i
//   rx_overflow_o    sticky, a word was dropped on a full FIFO
//   busy_o           a transaction is in progress (not Idle)
//   wdog_abort_o     one-cycle pulse when the watchdog aborts an Own phase
//   bus_*_io         shared bus, high-impedance when this node is not driving
module data_bus_node #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned CTRL_ID    = 3,
  parameter int unsigned OWNER_WAIT = 3,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ID_W-1:0]   node_id_i,
  input  logic              send_valid_i,
  input  logic [DATA_W-1:0] send_data_i,
  input  logic              send_last_i,
  output logic              send_ready_o,
  output logic              recv_valid_o,
  output logic [DATA_W-1:0] recv_data_o,
  output logic              recv_last_o,
  input  logic              recv_ready_i,
  output logic              rx_overflow_o,
  output logic              busy_o,
  output logic              wdog_abort_o,
  inout  wire  [DATA_W-1:0] bus_data_io,
  inout  wire               bus_valid_io,
  inout  wire               bus_last_io
);

  localparam int unsigned PtrW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(RX_DEPTH) + 1;
  localparam int unsigned WaitW = (OWNER_WAIT > 1) ? $clog2(OWNER_WAIT) : 1;
  localparam logic [ID_W-1:0] CtrlId = ID_W'(CTRL_ID);

  typedef enum logic [1:0] {StIdle, StWait, StOwn} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [ID_W-1:0]  src_q, src_d;
  logic [ID_W-1:0]  dst_q, dst_d;

  // Only a hard 1 counts as a bus word; z/x from an undriven bus is idle.
  logic bus_vld;
  logic bus_lst;
  assign bus_vld = (bus_valid_io === 1'b1);
  assign bus_lst = (bus_last_io === 1'b1);

  logic [ID_W-1:0] hdr_src;
  logic [ID_W-1:0] hdr_dst;
  assign hdr_src = bus_data_io[2*ID_W+1:ID_W+2];
  assign hdr_dst = bus_data_io[ID_W+1:2];

  logic wdog_fire;
  logic push_req;
  logic drive;

  // ---------------------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------------------
`ifdef DATA_BUS_WDOG_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_abort_q;

  // Counts consecutive Own cycles without a bus word; any word or leaving Own clears it.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_fire  = 1'b0;
    if (state_q == StOwn && !bus_vld) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
      if (wdog_cnt_d == WdogW'(TIMEOUT)) begin
        wdog_fire  = 1'b1;
        wdog_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_cnt_q   <= '0;
      wdog_abort_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_abort_q <= wdog_fire;
    end
  end

  assign wdog_abort_o = wdog_abort_q;
`else
  assign wdog_fire    = 1'b0;
  assign wdog_abort_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    case (state_q)
      StIdle: begin
        // A header flagged last is a complete header-only transaction.
        if (bus_vld && !bus_lst) begin
          state_d    = StWait;
          wait_cnt_d = '0;
          src_d      = hdr_src;
          dst_d      = hdr_dst;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WaitW'(OWNER_WAIT - 1)) begin
          state_d    = StOwn;
          wait_cnt_d = '0;
        end
      end
      StOwn: begin
        if ((bus_vld && bus_lst) || wdog_fire) begin
          state_d = StIdle;
          src_d   = '0;
          dst_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------
  always_comb begin
    send_ready_o = 1'b0;
    busy_o       = (state_q != StIdle);
    push_req     = 1'b0;
    case (state_q)
      StIdle: begin
        send_ready_o = !rst_i && (node_id_i == CtrlId);
        // Header goes to both the named source and destination.
        push_req     = bus_vld && ((node_id_i == hdr_src) || (node_id_i == hdr_dst));
      end
      StOwn: begin
        send_ready_o = !rst_i && (node_id_i == src_q);
        push_req     = bus_vld && (node_id_i == dst_q);
      end
      default: begin
        // Wait: nobody drives and stray bus words are ignored.
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Bus drivers
  // ---------------------------------------------------------------------------------------
  assign drive        = send_valid_i & send_ready_o;
  assign bus_data_io  = drive ? send_data_i : {DATA_W{1'bz}};
  assign bus_valid_io = drive ? 1'b1        : 1'bz;
  assign bus_last_io  = drive ? send_last_i : 1'bz;

  // ---------------------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------------------
  logic [DATA_W:0] mem_q [RX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(RX_DEPTH));
  assign pop   = !empty && recv_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (push_req && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_lst, bus_data_io};
    end
  end

  assign recv_valid_o  = !empty;
  assign recv_data_o   = empty ? '0   : mem_q[rd_ptr_q][DATA_W-1:0];
  assign recv_last_o   = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_W];
  assign rx_overflow_o = overflow_q;

endmodule

// File: tb/tb_data_bus_node.sv
// Bench for data_bus_node: four nodes on one shared bus. A behavioural model (transaction
// timeline in cycle numbers plus per-node word lists) is checked against the DUT on every
// falling edge. Directed scenarios with literal expectations run first, then random traffic.
module tb_data_bus_node;

  localparam int N          = 4;
  localparam int CTRL       = 3;
  localparam int OWNER_WAIT = 3;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] send_valid;
  logic [N-1:0] send_last;
  logic [N-1:0] recv_ready;
  logic [7:0]   send_data [N];

  wire [N-1:0] send_ready;
  wire [N-1:0] recv_valid;
  wire [N-1:0] recv_last;
  wire [N-1:0] rx_overflow;
  wire [N-1:0] busy;
  wire [N-1:0] wdog_abort;
  wire [7:0]   recv_data [N];

  wire [7:0] bus_data;
  wire       bus_valid;
  wire       bus_last;

  pulldown u_pd_valid (bus_valid);
  pulldown u_pd_last  (bus_last);

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_node
    data_bus_node u_node (
      .clk_i        (clk),
      .rst_i        (rst),
      .node_id_i    (2'(g)),
      .send_valid_i (send_valid[g]),
      .send_data_i  (send_data[g]),
      .send_last_i  (send_last[g]),
      .send_ready_o (send_ready[g]),
      .recv_valid_o (recv_valid[g]),
      .recv_data_o  (recv_data[g]),
      .recv_last_o  (recv_last[g]),
      .recv_ready_i (recv_ready[g]),
      .rx_overflow_o(rx_overflow[g]),
      .busy_o       (busy[g]),
      .wdog_abort_o (wdog_abort[g]),
      .bus_data_io  (bus_data),
      .bus_valid_io (bus_valid),
      .bus_last_io  (bus_last)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Behavioural model: transaction described by header cycle and derived ownership cycle.
  // ---------------------------------------------------------------------------------------
  bit         m_active;
  int         m_own_start;
  int         m_src;
  int         m_dst;
  int         m_silent;
  bit         m_abort;
  logic [8:0] mbuf [N][DEPTH];
  int         mcnt [N];
  bit         movf [N];
  int         cyc = 0;

  task automatic m_reset();
    m_active    = 1'b0;
    m_own_start = 0;
    m_src       = 0;
    m_dst       = 0;
    m_silent    = 0;
    m_abort     = 1'b0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      for (int k = 0; k < DEPTH; k++) mbuf[i][k] = '0;
    end
  endtask

  initial begin : cmp
    logic [N-1:0] exp_rdy;
    logic [N-1:0] tgt;
    logic [N-1:0] pop;
    logic [12:0]  exp_v;
    logic [12:0]  act_v;
    logic [7:0]   w;
    logic         l;
    int           drv;
    bit           m_idle;
    bit           m_own;
    m_reset();
    forever begin
      @(negedge clk);
      m_idle  = !m_active;
      m_own   = m_active && (cyc >= m_own_start);
      exp_rdy = '0;
      drv     = -1;
      for (int i = 0; i < N; i++) begin
        exp_rdy[i] = !rst && ((m_idle && i == CTRL) || (m_own && i == m_src));
        if (send_valid[i] && exp_rdy[i]) drv = i;
      end
      check("send_ready", 32'(send_ready), 32'(exp_rdy));
      check("bus_valid", 32'(bus_valid === 1'b1), 32'(drv >= 0));
      if (drv >= 0) begin
        check("bus_word", 32'({bus_last, bus_data}), 32'({send_last[drv], send_data[drv]}));
      end
      for (int i = 0; i < N; i++) begin
        exp_v = {mcnt[i] > 0, (mcnt[i] > 0) ? mbuf[i][0] : 9'h000, movf[i], m_active, m_abort};
        act_v = {recv_valid[i], recv_last[i], recv_data[i], rx_overflow[i], busy[i],
                 wdog_abort[i]};
        check($sformatf("node%0d_outputs", i), 32'(act_v), 32'(exp_v));
      end

      // Advance the model by what this cycle's bus activity must cause.
      if (rst) begin
        m_reset();
      end else begin
        tgt     = '0;
        m_abort = 1'b0;
        w       = '0;
        l       = 1'b0;
        for (int i = 0; i < N; i++) pop[i] = (mcnt[i] > 0) && recv_ready[i];
        if (drv >= 0) begin
          w = send_data[drv];
          l = send_last[drv];
          if (m_idle) begin
            tgt[w[5:4]] = 1'b1;
            tgt[w[3:2]] = 1'b1;
            if (!l) begin
              m_active    = 1'b1;
              m_own_start = cyc + OWNER_WAIT + 1;
              m_src       = int'(w[5:4]);
              m_dst       = int'(w[3:2]);
              m_silent    = 0;
            end
          end else if (m_own) begin
            tgt[m_dst] = 1'b1;
            m_silent   = 0;
            if (l) m_active = 1'b0;
          end
        end
`ifdef DATA_BUS_WDOG_EN
        else if (m_own) begin
          m_silent++;
          if (m_silent == TIMEOUT) begin
            m_active = 1'b0;
            m_abort  = 1'b1;
            m_silent = 0;
          end
        end
`endif
        for (int i = 0; i < N; i++) begin
          if (pop[i]) begin
            for (int k = 0; k < DEPTH - 1; k++) mbuf[i][k] = mbuf[i][k+1];
            mcnt[i]--;
          end
          if (tgt[i]) begin
            if (mcnt[i] < DEPTH) begin
              mbuf[i][mcnt[i]] = {l, w};
              mcnt[i]++;
            end else begin
              movf[i] = 1'b1;
            end
          end
        end
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    send_valid = '0;
    send_last  = '0;
    for (int i = 0; i < N; i++) send_data[i] = '0;
  endtask

  task automatic send_header(input logic [7:0] h, input logic lst);
    send_valid[CTRL] = 1'b1;
    send_data[CTRL]  = h;
    send_last[CTRL]  = lst;
    step();
    send_valid[CTRL] = 1'b0;
    send_last[CTRL]  = 1'b0;
  endtask

  task automatic expect_pop(input int n, input logic [8:0] exp, input string name);
    recv_ready[n] = 1'b1;
    #1;
    check(name, 32'({recv_valid[n], recv_last[n], recv_data[n]}), 32'({1'b1, exp}));
    step();
    recv_ready[n] = 1'b0;
  endtask

  initial begin : stim
    logic seen;
    rst        = 1'b1;
    recv_ready = '0;
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_recv_valid", 32'(recv_valid), 0);
    check("reset_ready", 32'(send_ready), 32'h8);

    // T1/T2: header 0x18 (src 1, dst 2), then node1 sends AA, BB(last).
    send_valid[CTRL] = 1'b1;
    send_data[CTRL]  = 8'h18;
    #1;
    check("t1_hdr_on_bus", 32'({bus_valid === 1'b1, bus_data}), 32'h118);
    step();
    send_valid[CTRL] = 1'b0;
    send_valid[1]    = 1'b1;
    send_data[1]     = 8'hAA;
    for (int k = 0; k < OWNER_WAIT; k++) begin
      #1;
      check("t2_wait_ready", 32'(send_ready[1]), 0);
      check("t2_wait_bus_idle", 32'(bus_valid === 1'b1), 0);
      if (k == 0) check("t1_rx_latency", 32'({recv_valid[2], recv_data[2]}), 32'h118);
      step();
    end
    #1;
    check("t2_src_ready", 32'(send_ready[1]), 1);
    step();
    send_data[1] = 8'hBB;
    send_last[1] = 1'b1;
    step();
    idle_inputs();
    #1;
    check("t1_idle_after_last", 32'(busy), 0);
    check("t1_ctrl_ready", 32'(send_ready), 32'h8);
    expect_pop(2, 9'h018, "t1_dst_hdr");
    expect_pop(2, 9'h0AA, "t1_dst_w0");
    expect_pop(2, 9'h1BB, "t1_dst_w1");
    expect_pop(1, 9'h018, "t1_src_hdr");
    #1;
    check("t1_no_echo", 32'(recv_valid), 0);

    // T3: fill node2 (header + 3 words), drop the 4th, accept the 5th alongside a pop.
    send_header(8'h18, 1'b0);
    repeat (OWNER_WAIT) step();
    send_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_data[1] = 8'(8'h11 * (k + 1));
      if (k == 3) begin
        #1;
        check("t3_no_ovf_yet", 32'(rx_overflow[2]), 0);
      end
      step();
    end
    #1;
    check("t3_overflow_set", 32'(rx_overflow[2]), 1);
    send_data[1]  = 8'h55;
    send_last[1]  = 1'b1;
    recv_ready[2] = 1'b1;
    step();
    idle_inputs();
    recv_ready[2] = 1'b0;
    expect_pop(2, 9'h011, "t3_rx0");
    expect_pop(2, 9'h022, "t3_rx1");
    expect_pop(2, 9'h033, "t3_rx2");
    expect_pop(2, 9'h155, "t3_rx3");
    expect_pop(1, 9'h018, "t3_src_hdr");
    #1;
    check("t3_drained", 32'(recv_valid), 0);
    check("t3_ovf_sticky", 32'(rx_overflow), 32'h4);

    // T4: header-only transaction 0x24 (src 2, dst 1).
    send_header(8'h24, 1'b1);
    #1;
    check("t4_busy", 32'(busy), 0);
    check("t4_ctrl_ready", 32'(send_ready[CTRL]), 1);
    expect_pop(1, 9'h124, "t4_dst_rx");
    expect_pop(2, 9'h124, "t4_src_rx");

    // T5: reset in the middle of an Own burst.
    send_header(8'h18, 1'b0);
    repeat (OWNER_WAIT) step();
    send_valid[1] = 1'b1;
    send_data[1]  = 8'h77;
    step();
    send_data[1] = 8'h88;
    rst          = 1'b1;
    #1;
    check("t5_rst_ready", 32'(send_ready), 0);
    check("t5_rst_bus", 32'(bus_valid === 1'b1), 0);
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_rx_empty", 32'(recv_valid), 0);
    check("t5_ovf_clr", 32'(rx_overflow), 0);
    check("t5_ready", 32'(send_ready), 32'h8);

    // T6: source stays silent in Own.
    send_header(8'h18, 1'b0);
    repeat (OWNER_WAIT) step();
    seen = 1'b0;
    #1;
    check("t6_src_ready", 32'(send_ready[1]), 1);
    for (int k = 0; k < TIMEOUT + 6; k++) begin
      step();
      #1;
      seen |= wdog_abort[1];
    end
`ifdef DATA_BUS_WDOG_EN
    check("t6_abort_seen", 32'(seen), 1);
    check("t6_idle", 32'(busy), 0);
`else
    check("t6_no_abort", 32'(seen), 0);
    check("t6_still_own", 32'(busy), 32'hF);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Random traffic, with a quiet window every 1000 cycles.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        send_valid[i] = ((c % 1000) < 900) && ($urandom_range(0, 1) == 1);
        send_data[i]  = 8'($urandom);
        send_last[i]  = ($urandom_range(0, 3) == 0);
        recv_ready[i] = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
    recv_ready = '1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
